// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX-stage divider and its user.
// The slave side is the divider; the master side is the issuing pipeline stage.
interface div_unit_if;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o,
        output stallreq_o
    );

    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o,
        input  stallreq_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit signed/unsigned divider with EX-stage stall request.
// One quotient bit per cycle; result is {remainder, quotient}.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_work;
    logic [31:0] r_divisor;
    logic        r_sign1;
    logic        r_sign2;
    logic        r_signed;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [64:0] w_shift;
    logic [32:0] w_diff;
    logic [63:0] w_next;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // Magnitudes of the incoming operands for the signed case
    always_comb begin
        w_abs1 = bus.opdata1_i;
        w_abs2 = bus.opdata2_i;
        if (bus.signed_div_i && bus.opdata1_i[31]) begin
            w_abs1 = ~bus.opdata1_i + 32'd1;
        end else begin
            w_abs1 = bus.opdata1_i;
        end
        if (bus.signed_div_i && bus.opdata2_i[31]) begin
            w_abs2 = ~bus.opdata2_i + 32'd1;
        end else begin
            w_abs2 = bus.opdata2_i;
        end
    end

    // One restoring step; partial remainder always stays below the divisor,
    // so the 33-bit difference sign is enough to decide the quotient bit.
    always_comb begin
        w_shift = {r_work, 1'b0};
        w_diff  = w_shift[64:32] - {1'b0, r_divisor};
        if (!w_diff[32]) begin
            w_next = {w_diff[31:0], w_shift[31:1], 1'b1};
        end else begin
            w_next = w_shift[63:0];
        end
    end

    // Sign correction: quotient negated on sign mismatch, remainder follows dividend
    always_comb begin
        w_quot_fix = r_work[31:0];
        w_rem_fix  = r_work[63:32];
        if (r_signed && (r_sign1 ^ r_sign2)) begin
            w_quot_fix = ~r_work[31:0] + 32'd1;
        end else begin
            w_quot_fix = r_work[31:0];
        end
        if (r_signed && r_sign1) begin
            w_rem_fix = ~r_work[63:32] + 32'd1;
        end else begin
            w_rem_fix = r_work[63:32];
        end
    end

    // Control FSM, iteration datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 64'd0;
            r_divisor <= 32'd0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            r_state <= S_BYZERO;
                        end else begin
                            r_state   <= S_ON;
                            r_work    <= {32'd0, w_abs1};
                            r_divisor <= w_abs2;
                            r_sign1   <= bus.opdata1_i[31];
                            r_sign2   <= bus.opdata2_i[31];
                            r_signed  <= bus.signed_div_i;
                            r_cnt     <= 6'd0;
                        end
                    end else begin
                        r_state <= S_FREE;
                    end
                end
                S_BYZERO: begin
                    r_state  <= S_END;
                    r_result <= 64'd0;
                    r_ready  <= 1'b1;
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        r_state <= S_FREE;
                    end else if (r_cnt != 6'd32) begin
                        r_work <= w_next;
                        r_cnt  <= r_cnt + 6'd1;
                    end else begin
                        r_result <= {w_rem_fix, w_quot_fix};
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_END: begin
                    if (!bus.start_i) begin
                        r_state  <= S_FREE;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_state <= S_END;
                    end
                end
                default: begin
                    r_state <= S_FREE;
                end
            endcase
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.stallreq_o = bus.start_i & ~r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized divides
// checked against an arithmetic reference model.
module tb_div_unit;

    logic clk;
    logic rst;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    div_unit_if bus_if ();

    div_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
        end
        return {r, q};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising ready_o pops one expected result and its arrival cycle
    initial begin
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.ready_o === 1'b1 && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got result %h with no division pending", bus_if.result_o);
                end else begin
                    e = sb_q.pop_front();
                    check("result", bus_if.result_o, e.res);
                    check("latency", 64'(edge_cnt), 64'(e.cyc));
                end
            end
            prev = bus_if.ready_o;
        end
    end

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit scramble);
        int          n;
        bit          got;
        logic [63:0] exp;
        exp = ref_div(s, a, b);
        @(negedge clk);
        bus_if.signed_div_i = s;
        bus_if.opdata1_i    = a;
        bus_if.opdata2_i    = b;
        bus_if.start_i      = 1'b1;
        n = edge_cnt;
        sb_q.push_back('{exp, n + ((b == 32'd0) ? 2 : 34)});
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus_if.ready_o === 1'b1) begin
                got = 1'b1;
            end else begin
                check("stall_busy", {63'd0, bus_if.stallreq_o}, 64'd1);
                if (scramble && edge_cnt == n + 5) begin
                    bus_if.opdata1_i    = $urandom;
                    bus_if.opdata2_i    = $urandom;
                    bus_if.signed_div_i = ~s;
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready_o expected one within 60 cycles (a=%h b=%h)", a, b);
        end else begin
            check("stall_at_ready", {63'd0, bus_if.stallreq_o}, 64'd0);
            if ($urandom_range(0, 1) == 1) begin
                bus_if.annul_i = $urandom_range(0, 1);
                @(negedge clk);
                check("end_hold_ready", {63'd0, bus_if.ready_o}, 64'd1);
                check("end_hold_result", bus_if.result_o, exp);
                bus_if.annul_i = 1'b0;
            end
        end
        bus_if.start_i = 1'b0;
        @(negedge clk);
        check("clear_ready", {63'd0, bus_if.ready_o}, 64'd0);
        check("clear_result", bus_if.result_o, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst                 = 1'b1;
        bus_if.start_i      = 1'b0;
        bus_if.annul_i      = 1'b0;
        bus_if.signed_div_i = 1'b0;
        bus_if.opdata1_i    = 32'd0;
        bus_if.opdata2_i    = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, bus_if.ready_o}, 64'd0);
        check("rst_result", bus_if.result_o, 64'd0);
        check("rst_stall_idle", {63'd0, bus_if.stallreq_o}, 64'd0);
        bus_if.start_i = 1'b1;
        #1;
        check("rst_stall_start", {63'd0, bus_if.stallreq_o}, 64'd1);
        bus_if.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, 1'b1);
        check("ref_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b1);
        do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        do_div(1'b0, 32'h00000003, 32'hFFFFFFFF, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, 1'b0);
        do_div(1'b1, 32'd5, 32'd0, 1'b1);

        // Annul mid-division: no result may ever appear
        @(negedge clk);
        bus_if.signed_div_i = 1'b0;
        bus_if.opdata1_i    = 32'd1000;
        bus_if.opdata2_i    = 32'd3;
        bus_if.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus_if.annul_i = 1'b1;
        @(negedge clk);
        bus_if.annul_i = 1'b0;
        bus_if.start_i = 1'b0;
        check("annul_ready", {63'd0, bus_if.ready_o}, 64'd0);
        repeat (40) @(negedge clk);
        check("annul_ready_late", {63'd0, bus_if.ready_o}, 64'd0);
        do_div(1'b0, 32'd9, 32'd3, 1'b0);

        // start together with annul in FREE must not launch a division
        @(negedge clk);
        bus_if.opdata1_i = 32'd50;
        bus_if.opdata2_i = 32'd5;
        bus_if.start_i   = 1'b1;
        bus_if.annul_i   = 1'b1;
        repeat (3) @(negedge clk);
        check("annul_free_stall", {63'd0, bus_if.stallreq_o}, 64'd1);
        bus_if.start_i = 1'b0;
        bus_if.annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_free_ready", {63'd0, bus_if.ready_o}, 64'd0);

        // Reset mid-division discards the operation
        @(negedge clk);
        bus_if.opdata1_i = 32'd77;
        bus_if.opdata2_i = 32'd7;
        bus_if.start_i   = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus_if.start_i = 1'b0;
        check("midrst_ready", {63'd0, bus_if.ready_o}, 64'd0);
        check("midrst_result", bus_if.result_o, 64'd0);
        repeat (40) @(negedge clk);
        check("midrst_ready_late", {63'd0, bus_if.ready_o}, 64'd0);
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                2:       a = $urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 50);
                default: b = $urandom;
            endcase
            do_div(1'($urandom_range(0, 1)), a, b, bit'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
